multicycle_controller: RTL

- Moore/Mealy FSM that sequences the multi-cycle RV32I datapath: instruction fetch, decode, execute, memory and writeback.
- Drives the mux selects and write enables for PC, IR, ALU, register file and the unified memory port.
- Times execute so the registered immediate from immediate_generator (1-cycle latency from IR) is valid when consumed.
- Adds a memory-wait watchdog and a sticky trap state.

---
 rtl/multicycle_pkg.sv | 56 +++++
 rtl/mem_watchdog.sv | 29 ++
 rtl/multicycle_controller.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared states, opcodes and datapath select encodings for the multicycle controller
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_ADDR,
        S_MEM,
        S_EXEC_ALU,
        S_EXEC_BRANCH,
        S_BR_TARGET,
        S_EXEC_JAL,
        S_EXEC_JALR,
        S_EXEC_AUIPC,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALU_A_PC     = 2'd0;
    localparam logic [1:0] ALU_A_OLD_PC = 2'd1;
    localparam logic [1:0] ALU_A_RS1    = 2'd2;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [1:0] TRAP_NONE        = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'd1;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'd2;

    // Stores and loads share EXEC_ADDR/MEM; only the write strobe and the exit differ
    function automatic logic is_store(input logic [6:0] op);
        return op == OP_STORE;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - counts stalled memory-request cycles and flags a timeout
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count stalled cycles; saturate at the limit so the counter never wraps
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (start && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Timeout only while still stalling, so a same-cycle ready always wins
    assign timeout = start && (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FSM sequencing fetch/decode/execute/memory/writeback for a multicycle RV32I core
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src_sel,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] wb_sel_q;
    logic [1:0] wb_sel_d;
    logic       retire_q;
    logic       retire_d;
    logic       trap_q;
    logic [1:0] trap_cause_q;
    logic [1:0] trap_cause_d;

    logic       in_mem_wait;
    logic       wd_start;
    logic       wd_clear;
    logic       wd_timeout;

    assign in_mem_wait = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wd_start    = in_mem_wait && !mem_ready;
    assign wd_clear    = !in_mem_wait || mem_ready;

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (wd_start),
        .clear   (wd_clear),
        .timeout (wd_timeout)
    );

    // State, writeback select, retire pulse and sticky trap registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wb_sel_q     <= WB_ALU;
            retire_q     <= 1'b0;
            trap_q       <= 1'b0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
            if (state_d == S_WB) begin
                wb_sel_q <= wb_sel_d;
            end
            if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
                trap_q       <= 1'b1;
                trap_cause_q <= trap_cause_d;
            end
        end
    end

    // Next-state and datapath control decode; reset overrides every output
    always_comb begin
        state_d       = state_q;
        wb_sel_d      = WB_ALU;
        retire_d      = 1'b0;
        trap_cause_d  = TRAP_NONE;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src_sel    = 1'b0;
        alu_a_sel     = ALU_A_PC;
        alu_b_sel     = ALU_B_RS2;
        alu_op        = ALU_OP_ADD;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        instr_retired = retire_q;
        trap          = trap_q;
        trap_cause    = trap_cause_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_a_sel = ALU_A_PC;
                alu_b_sel = ALU_B_FOUR;
                alu_op    = ALU_OP_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wd_timeout) begin
                    trap_cause_d = TRAP_MEM_TIMEOUT;
                    state_d      = S_TRAP;
                end
            end

            // Register file read and immediate register settle this cycle
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_EXEC_ADDR;
                    OP_OP, OP_OPIMM:   state_d = S_EXEC_ALU;
                    OP_BRANCH:         state_d = S_EXEC_BRANCH;
                    OP_JAL:            state_d = S_EXEC_JAL;
                    OP_JALR:           state_d = S_EXEC_JALR;
                    OP_AUIPC:          state_d = S_EXEC_AUIPC;
                    OP_LUI: begin
                        wb_sel_d = WB_IMM;
                        state_d  = S_WB;
                    end
                    default: begin
                        trap_cause_d = TRAP_ILLEGAL;
                        state_d      = S_TRAP;
                    end
                endcase
            end

            S_EXEC_ADDR: begin
                alu_a_sel = ALU_A_RS1;
                alu_b_sel = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
                state_d   = S_MEM;
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store(opcode);
                if (mem_ready) begin
                    if (is_store(opcode)) begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        wb_sel_d = WB_MEM;
                        state_d  = S_WB;
                    end
                end else if (wd_timeout) begin
                    trap_cause_d = TRAP_MEM_TIMEOUT;
                    state_d      = S_TRAP;
                end
            end

            // opcode[5] separates register-register from register-immediate
            S_EXEC_ALU: begin
                alu_a_sel = ALU_A_RS1;
                alu_b_sel = opcode[5] ? ALU_B_RS2 : ALU_B_IMM;
                alu_op    = ALU_OP_FUNCT;
                wb_sel_d  = WB_ALU;
                state_d   = S_WB;
            end

            S_EXEC_BRANCH: begin
                alu_a_sel = ALU_A_RS1;
                alu_b_sel = ALU_B_RS2;
                alu_op    = ALU_OP_BRANCH;
                if (branch_taken) begin
                    state_d = S_BR_TARGET;
                end else begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end

            S_BR_TARGET: begin
                alu_a_sel = ALU_A_OLD_PC;
                alu_b_sel = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
                pc_write  = 1'b1;
                retire_d  = 1'b1;
                state_d   = S_FETCH;
            end

            S_EXEC_JAL: begin
                alu_a_sel = ALU_A_OLD_PC;
                alu_b_sel = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
                pc_write  = 1'b1;
                wb_sel_d  = WB_LINK;
                state_d   = S_WB;
            end

            // JALR target must have bit0 cleared before loading the PC
            S_EXEC_JALR: begin
                alu_a_sel  = ALU_A_RS1;
                alu_b_sel  = ALU_B_IMM;
                alu_op     = ALU_OP_ADD;
                pc_write   = 1'b1;
                pc_src_sel = 1'b1;
                wb_sel_d   = WB_LINK;
                state_d    = S_WB;
            end

            S_EXEC_AUIPC: begin
                alu_a_sel = ALU_A_OLD_PC;
                alu_b_sel = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
                wb_sel_d  = WB_ALU;
                state_d   = S_WB;
            end

            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = wb_sel_q;
                retire_d  = 1'b1;
                state_d   = S_FETCH;
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_addr_sel  = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src_sel    = 1'b0;
            alu_a_sel     = ALU_A_PC;
            alu_b_sel     = ALU_B_RS2;
            alu_op        = ALU_OP_ADD;
            reg_write     = 1'b0;
            wb_sel        = WB_ALU;
            instr_retired = 1'b0;
            trap          = 1'b0;
            trap_cause    = TRAP_NONE;
        end
    end

endmodule
